life_sequencer: RTL
===================

// Module: life_sequencer
// PURPOSE
//  Top-level run controller for the Game of Life field. Sequences the ROM loader, then the
//  generation engine, at a programmable rate, and grants field-memory ownership to one at a time.
//  Handles user start/pause/single-step/reload requests.
//  Sits between the button debouncers and the loader/engine/display-buffer logic.
// PARAMETERS
//  PERIOD_W  24  width of i_period (clock cycles between generation starts)
//  GEN_W     16  width of o_gen_count
// PORTS
//  clk           in   1        system clock; single clock domain
//  rst           in   1        synchronous, active-high reset
//  i_start       in   1        1-cycle pulse: load field from ROM, then run
//  i_pause       in   1        1-cycle pulse: toggle paused/running
//  i_step        in   1        1-cycle pulse: compute one generation while paused
//  i_reload      in   1        1-cycle pulse: reload ROM pattern, keep pause state
//  i_period      in   PERIOD_W cycles to wait before each generation; 0 = back-to-back
//  o_load_go     out  1        1-cycle pulse to loader
//  i_load_busy   in   1        loader busy; must rise the cycle after o_load_go
//  o_step_go     out  1        1-cycle pulse to engine
//  i_step_busy   in   1        engine busy; must rise the cycle after o_step_go
//  o_owner       out  2        field-memory owner: owner_t NONE/LOADER/ENGINE
//  o_frame_swap  out  1        1-cycle pulse: new generation complete, swap display buffer
//  o_gen_count   out  GEN_W    generations since last load
//  o_paused      out  1        paused flag
// BEHAVIOUR
//  Reset: state IDLE, paused=0, gen_count=0, timer=0, reload_pend=0.
//   All pulse outputs 0; o_owner=NONE.
//  States (seq_state_t): IDLE, LOAD_REQ, LOAD_WAIT, WAIT_TICK, PAUSED, STEP_REQ, STEP_WAIT, SWAP.
//  IDLE: i_start -> LOAD_REQ. All other inputs are ignored.
//  LOAD_REQ: o_load_go=1 for exactly this cycle -> LOAD_WAIT unconditionally.
//  LOAD_WAIT: wait for i_load_busy==0.
//   On exit: gen_count<=0.
//   Next state: PAUSED if paused, else WAIT_TICK.
//  WAIT_TICK: on entry, timer<=i_period (sampled once per entry).
//   timer==0 -> STEP_REQ; otherwise decrement each cycle.
//   Period P gives exactly P+1 cycles in WAIT_TICK.
//  STEP_REQ: o_step_go=1 for one cycle -> STEP_WAIT.
//  STEP_WAIT: wait for i_step_busy==0 -> SWAP.
//  SWAP: o_frame_swap=1 for one cycle; gen_count<=gen_count+1 (wraps mod 2^GEN_W).
//   Next state, first match: LOAD_REQ if reload_pend (then clear reload_pend);
//   else PAUSED if paused; else WAIT_TICK.
//  PAUSED: i_pause -> paused<=0, go to WAIT_TICK (timer reloads). i_step -> STEP_REQ;
//   paused stays 1, so SWAP returns to PAUSED.
//  i_pause in WAIT_TICK: toggles paused<=1 and goes to PAUSED at once; the timer is discarded.
//  i_pause in LOAD_*/STEP_*/SWAP: toggles paused only.
//   The new value applies at the next decision point; the current operation always completes.
//  i_reload:
//   - in WAIT_TICK/PAUSED: -> LOAD_REQ next cycle.
//   - in STEP_REQ/STEP_WAIT/SWAP: sets reload_pend; served at the next SWAP exit.
//     A reload arriving in SWAP itself takes effect in that same exit.
//   - in LOAD_*: ignored (a load is already in flight).
//   - in IDLE: ignored.
//  Simultaneous pulses, priority reload > pause > step.
//   A lower-priority pulse in the same cycle is dropped, except that pause still toggles paused.
//  i_step while running (not PAUSED): ignored. i_start outside IDLE: ignored.
//  o_owner = LOADER in LOAD_REQ/LOAD_WAIT; ENGINE in STEP_REQ/STEP_WAIT; NONE otherwise.
//   Changes only on state registers, never combinationally from inputs.
//  All outputs are decoded from registered state; no input->output combinational path.
//  rst mid-operation: returns to IDLE next edge and drops ownership.
//   Loader/engine have their own reset; the sequencer does not wait for them.
// STRUCTURE
//  life_pkg: seq_state_t enum, owner_t enum {OWN_NONE, OWN_LOADER, OWN_ENGINE}.
//   Shared with loader/engine wrappers.
//  Sub-module gen_timer (load/decrement/zero flag, PERIOD_W wide), instantiated once.
//  Single always_comb next-state block plus one always_ff state register.
// TESTING
//  1 rst, then i_start; loader busy 5 cyc -> one o_load_go, owner=LOADER 6 cyc.
//    Then WAIT_TICK with gen_count=0.
//  2 i_period=3, engine busy 2 cyc -> o_step_go every 8 cyc (4+1+2+1).
//    o_frame_swap each time; gen_count 1,2,3.
//  3 i_pause in WAIT_TICK -> PAUSED next cyc, no o_step_go for 100 cyc.
//    i_step -> exactly one swap, back to PAUSED.
//  4 i_reload during STEP_WAIT -> SWAP completes, then LOAD_REQ; gen_count resets to 0 after load.
//  5 reload+pause+step same cycle in PAUSED -> reload served, paused=0, no step.
//    i_period=0 -> back-to-back steps.
//  6 gen_count at 2^GEN_W-1 -> wraps to 0; rst in STEP_WAIT -> IDLE, owner=NONE next cyc.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types for the Game of Life run controller, loader and engine wrappers.
package life_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OWNER_W = 2;

  typedef logic [STATE_W-1:0] seq_state_t;

  localparam seq_state_t S_IDLE      = 3'd0;
  localparam seq_state_t S_LOAD_REQ  = 3'd1;
  localparam seq_state_t S_LOAD_WAIT = 3'd2;
  localparam seq_state_t S_WAIT_TICK = 3'd3;
  localparam seq_state_t S_PAUSED    = 3'd4;
  localparam seq_state_t S_STEP_REQ  = 3'd5;
  localparam seq_state_t S_STEP_WAIT = 3'd6;
  localparam seq_state_t S_SWAP      = 3'd7;

  typedef enum logic [OWNER_W-1:0] {
    OWN_NONE   = 2'd0,
    OWN_LOADER = 2'd1,
    OWN_ENGINE = 2'd2
  } owner_t;

  // Field-memory owner implied by a sequencer state.
  function automatic owner_t owner_of(input seq_state_t s);
    owner_t o;
    o = OWN_NONE;
    if (s == S_LOAD_REQ || s == S_LOAD_WAIT) o = OWN_LOADER;
    if (s == S_STEP_REQ || s == S_STEP_WAIT) o = OWN_ENGINE;
    return o;
  endfunction

endpackage

// File: rtl/gen_timer.sv
// Loadable down-counter pacing generation starts; zero_c flags expiry.
module gen_timer #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/life_sequencer.sv
// Run controller: sequences ROM load and generation steps, arbitrates field-memory ownership.
module life_sequencer
  import life_pkg::*;
#(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned GEN_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_step,
  input  logic                i_reload,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_load_go,
  input  logic                i_load_busy,
  output logic                o_step_go,
  input  logic                i_step_busy,
  output logic [OWNER_W-1:0]  o_owner,
  output logic                o_frame_swap,
  output logic [GEN_W-1:0]    o_gen_count,
  output logic                o_paused
);

  seq_state_t       state_q, state_next;
  logic             paused_q, paused_next;
  logic             reload_q, reload_next;
  logic [GEN_W-1:0] gen_q, gen_next;
  logic             tmr_load, tmr_dec, tmr_zero_c;

  gen_timer #(.W(PERIOD_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (i_period),
    .zero_c   (tmr_zero_c)
  );

  // Timer reloads on every entry into WAIT_TICK, counts down while resident.
  assign tmr_load = (state_next == S_WAIT_TICK) && (state_q != S_WAIT_TICK);
  assign tmr_dec  = (state_q == S_WAIT_TICK);

  always_comb begin
    state_next  = state_q;
    paused_next = paused_q;
    reload_next = reload_q;
    gen_next    = gen_q;

    // Pause toggles the flag everywhere but IDLE, even when a reload wins the cycle.
    if (state_q != S_IDLE && i_pause) paused_next = ~paused_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) state_next = S_LOAD_REQ;
      end
      S_LOAD_REQ: begin
        state_next = S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        if (!i_load_busy) begin
          gen_next   = '0;
          state_next = paused_next ? S_PAUSED : S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (i_reload)        state_next = S_LOAD_REQ;
        else if (i_pause)    state_next = S_PAUSED;
        else if (tmr_zero_c) state_next = S_STEP_REQ;
      end
      S_PAUSED: begin
        if (i_reload)     state_next = S_LOAD_REQ;
        else if (i_pause) state_next = S_WAIT_TICK;
        else if (i_step)  state_next = S_STEP_REQ;
      end
      S_STEP_REQ: begin
        if (i_reload) reload_next = 1'b1;
        state_next = S_STEP_WAIT;
      end
      S_STEP_WAIT: begin
        if (i_reload) reload_next = 1'b1;
        if (!i_step_busy) state_next = S_SWAP;
      end
      S_SWAP: begin
        gen_next = gen_q + GEN_W'(1);
        if (reload_q || i_reload) begin
          reload_next = 1'b0;
          state_next  = S_LOAD_REQ;
        end else if (paused_next) begin
          state_next = S_PAUSED;
        end else begin
          state_next = S_WAIT_TICK;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      paused_q     <= 1'b0;
      reload_q     <= 1'b0;
      gen_q        <= '0;
      o_load_go    <= 1'b0;
      o_step_go    <= 1'b0;
      o_frame_swap <= 1'b0;
      o_owner      <= OWNER_W'(OWN_NONE);
    end else begin
      state_q      <= state_next;
      paused_q     <= paused_next;
      reload_q     <= reload_next;
      gen_q        <= gen_next;
      o_load_go    <= (state_next == S_LOAD_REQ);
      o_step_go    <= (state_next == S_STEP_REQ);
      o_frame_swap <= (state_next == S_SWAP);
      o_owner      <= OWNER_W'(owner_of(state_next));
    end
  end

  assign o_gen_count = gen_q;
  assign o_paused    = paused_q;

endmodule
